mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory of the multi-cycle core between two requesters: instruction fetch (read-only) and load/store data (read/write).
- Accepts one transaction at a time: latches it, drives the memory port, waits the fixed memory read latency, and returns data or a write acknowledge to the winner.
- Data accesses have priority; a starvation counter bounds how long fetch can be delayed.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port instruction/data memory between fetch and load/store.
// Data accesses win ties. A starvation counter forces a fetch grant after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
    localparam logic [3:0] LatMax    = 4'(MEM_LAT);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          dwin_q, dwin_d;
    logic [3:0]    starve_q, starve_d;
    logic [3:0]    lat_q, lat_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic forceIf;
    logic pickIf;
    logic pickD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            dwin_q     <= 1'b0;
            starve_q   <= '0;
            lat_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            dwin_q     <= dwin_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Arbitration happens on the edge leaving IDLE or DONE, so DONE can chain straight into ISSUE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        dwin_d     = dwin_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        forceIf = (STARVE_MAX != 0) && (starve_q == StarveMax);
        pickIf  = if_req && (!d_req || forceIf);
        pickD   = d_req && !pickIf;

        unique case (state_q)
            IDLE, DONE: begin
                if (pickIf || pickD) begin
                    state_d = ISSUE;
                    dwin_d  = pickD;
                    we_d    = pickD && d_we;
                    addr_d  = pickD ? d_addr : if_addr;
                    if (pickD) begin
                        wdata_d = d_wdata;
                    end
                    if (pickIf) begin
                        starve_d = '0;
                    end else if (if_req && starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                lat_d   = 4'd1;
                state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_q == LatMax) begin
                    state_d = DONE;
                    if (dwin_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so a reset drops them without waiting for a clock.
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = (state_q == ISSUE) && !dwin_q;
    assign d_gnt     = (state_q == ISSUE) && dwin_q;
    assign if_rvalid = (state_q == DONE) && !dwin_q;
    assign d_done    = (state_q == DONE) && dwin_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: dut0 uses MEM_LAT=1/STARVE_MAX=3, dut1 uses MEM_LAT=4/STARVE_MAX=0.
// Completions are popped from per-port queues filled at grant time and checked for data and cycle.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        isLoad;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifReq[2];
    logic [31:0] ifAddr[2];
    logic        dReq[2];
    logic        dWe[2];
    logic [31:0] dAddr[2];
    logic [31:0] dWdata[2];
    logic        ifGnt[2];
    logic        ifRvalid[2];
    logic [31:0] ifRdata[2];
    logic        dGnt[2];
    logic        dDone[2];
    logic [31:0] dRdata[2];
    logic        memEn[2];
    logic        memWe[2];
    logic [31:0] memAddr[2];
    logic [31:0] memWdata[2];
    logic [31:0] memRdata[2];
    logic        busy[2];

    logic [31:0] pipe0;
    logic [31:0] pipe1[4];

    exp_t ifQ0[$], ifQ1[$], dQ0[$], dQ1[$];
    byte  gLog0[$], gLog1[$];
    int   gCyc0[$], gCyc1[$];
    int   memEnCnt[2] = '{0, 0};
    int   cycle = 0;
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(3)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(ifReq[0]), .if_addr(ifAddr[0]), .if_gnt(ifGnt[0]),
        .if_rvalid(ifRvalid[0]), .if_rdata(ifRdata[0]),
        .d_req(dReq[0]), .d_we(dWe[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
        .d_gnt(dGnt[0]), .d_done(dDone[0]), .d_rdata(dRdata[0]),
        .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]),
        .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4), .STARVE_MAX(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(ifReq[1]), .if_addr(ifAddr[1]), .if_gnt(ifGnt[1]),
        .if_rvalid(ifRvalid[1]), .if_rdata(ifRdata[1]),
        .d_req(dReq[1]), .d_we(dWe[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
        .d_gnt(dGnt[1]), .d_done(dDone[1]), .d_rdata(dRdata[1]),
        .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]),
        .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1]), .busy(busy[1])
    );

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'h2008_0045;
    endfunction

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Read data is only valid exactly MEM_LAT cycles after the strobe; other cycles carry a poison value.
    always @(posedge clk) begin
        pipe0 <= memEn[0] ? memData(memAddr[0]) : 32'hBADB_AD00;
        pipe1[0] <= memEn[1] ? memData(memAddr[1]) : 32'hBADB_AD01;
        for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
    end
    assign memRdata[0] = pipe0;
    assign memRdata[1] = pipe1[3];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic pushExp(input int d, input bit isData, input exp_t e);
        if (d == 0) begin
            if (isData) dQ0.push_back(e); else ifQ0.push_back(e);
        end else begin
            if (isData) dQ1.push_back(e); else ifQ1.push_back(e);
        end
    endtask

    task automatic logGrant(input int d, input byte kind);
        if (d == 0) begin
            gLog0.push_back(kind); gCyc0.push_back(cycle);
        end else begin
            gLog1.push_back(kind); gCyc1.push_back(cycle);
        end
    endtask

    task automatic completeCheck(input int d, input bit isData, input logic [31:0] rdata);
        exp_t e;
        bit   empty;
        if (d == 0) empty = isData ? (dQ0.size() == 0) : (ifQ0.size() == 0);
        else        empty = isData ? (dQ1.size() == 0) : (ifQ1.size() == 0);
        if (empty) begin
            checkOutput($sformatf("dut%0d_%s_unexpected", d, isData ? "d_done" : "if_rvalid"), 1, 0);
        end else begin
            if (d == 0) e = isData ? dQ0.pop_front() : ifQ0.pop_front();
            else        e = isData ? dQ1.pop_front() : ifQ1.pop_front();
            if (e.isLoad) checkOutput($sformatf("dut%0d_%s", d, isData ? "d_rdata" : "if_rdata"), rdata, e.data);
            checkOutput($sformatf("dut%0d_%s_cycle", d, isData ? "d_done" : "if_rvalid"), cycle, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (memEn[d]) memEnCnt[d]++;
                if (ifGnt[d]) logGrant(d, "I");
                if (dGnt[d]) logGrant(d, "D");
                if (ifRvalid[d]) completeCheck(d, 1'b0, ifRdata[d]);
                if (dDone[d]) completeCheck(d, 1'b1, dRdata[d]);
            end
        end
    end

    // Raises one request, waits (bounded) for its grant, checks the memory port in the ISSUE cycle.
    task automatic applyStimulus(input int d, input bit isData, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expectDone, input bit keepReq,
                                 output int gntCycle);
        bit   got = 1'b0;
        exp_t e;
        if (isData) begin
            dReq[d] = 1'b1; dWe[d] = we; dAddr[d] = addr; dWdata[d] = wdata;
        end else begin
            ifReq[d] = 1'b1; ifAddr[d] = addr;
        end
        gntCycle = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = isData ? dGnt[d] : ifGnt[d];
        end
        if (!got) begin
            checkOutput($sformatf("dut%0d_gnt_timeout", d), 0, 1);
            dReq[d] = isData ? 1'b0 : dReq[d];
            ifReq[d] = isData ? ifReq[d] : 1'b0;
            return;
        end
        gntCycle = cycle;
        checkOutput($sformatf("dut%0d_mem_en_at_gnt", d), memEn[d], 1);
        checkOutput($sformatf("dut%0d_mem_we_at_gnt", d), memWe[d], we);
        checkOutput($sformatf("dut%0d_mem_addr_at_gnt", d), memAddr[d], addr);
        if (we) checkOutput($sformatf("dut%0d_mem_wdata_at_gnt", d), memWdata[d], wdata);
        if (expectDone) begin
            e.data = memData(addr);
            e.isLoad = !we;
            e.due = cycle + (we ? 1 : latOf(d) + 1);
            pushExp(d, isData, e);
        end
        if (!keepReq) begin
            if (isData) dReq[d] = 1'b0; else ifReq[d] = 1'b0;
        end
    endtask

    task automatic streamTxn(input int d, input bit isData, input int n, input logic [31:0] base);
        int gc;
        for (int k = 0; k < n; k++) begin
            applyStimulus(d, isData, 1'b0, base + 32'(k * 4), 32'h0, 1'b1, (k != n - 1), gc);
        end
    endtask

    task automatic checkIdleOutputs(input int d, input string phase);
        checkOutput($sformatf("%s%0d_busy", phase, d), busy[d], 0);
        checkOutput($sformatf("%s%0d_mem_en", phase, d), memEn[d], 0);
        checkOutput($sformatf("%s%0d_mem_we", phase, d), memWe[d], 0);
        checkOutput($sformatf("%s%0d_mem_addr", phase, d), memAddr[d], 0);
        checkOutput($sformatf("%s%0d_if_gnt", phase, d), ifGnt[d], 0);
        checkOutput($sformatf("%s%0d_d_gnt", phase, d), dGnt[d], 0);
        checkOutput($sformatf("%s%0d_if_rvalid", phase, d), ifRvalid[d], 0);
        checkOutput($sformatf("%s%0d_d_done", phase, d), dDone[d], 0);
        checkOutput($sformatf("%s%0d_if_rdata", phase, d), ifRdata[d], 0);
        checkOutput($sformatf("%s%0d_d_rdata", phase, d), dRdata[d], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    gc;
        int    c0;
        int    base;
        string ord0 = "DDDIDDDI";
        string ord1 = "DDDDDI";
        for (int d = 0; d < 2; d++) begin
            ifReq[d] = 1'b0; ifAddr[d] = '0; dReq[d] = 1'b0; dWe[d] = 1'b0; dAddr[d] = '0; dWdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        checkIdleOutputs(0, "rst");
        checkIdleOutputs(1, "rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single fetch read");
        c0 = cycle;
        applyStimulus(0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, gc);
        checkOutput("read_gnt_latency", gc, c0 + 1);
        repeat (4) @(negedge clk);

        $display("[TB] single store");
        applyStimulus(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, gc);
        repeat (2) @(negedge clk);
        checkOutput("store_after_mem_we", memWe[0], 0);
        checkOutput("store_after_mem_en", memEn[0], 0);
        checkOutput("store_after_mem_addr_hold", memAddr[0], 32'h100);
        checkOutput("store_after_mem_wdata_hold", memWdata[0], 32'hDEAD_BEEF);
        checkOutput("store_after_busy", busy[0], 0);

        $display("[TB] reset during fetch wait");
        applyStimulus(0, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, gc);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkIdleOutputs(0, "midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] contention with starvation limit 3");
        base = gLog0.size();
        fork
            streamTxn(0, 1'b1, 6, 32'h1000);
            streamTxn(0, 1'b0, 2, 32'h2000);
        join
        repeat (5) @(negedge clk);
        checkOutput("contention_grant_count", gLog0.size() - base, 8);
        if (gLog0.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) checkOutput($sformatf("contention_order%0d", i), gLog0[base+i], ord0[i]);
            for (int i = 1; i < 8; i++) checkOutput($sformatf("contention_gap%0d", i), gCyc0[base+i] - gCyc0[base+i-1], 3);
        end

        $display("[TB] latency 4 load");
        applyStimulus(1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, gc);
        repeat (8) @(negedge clk);

        $display("[TB] contention with pure data priority");
        base = gLog1.size();
        fork
            streamTxn(1, 1'b1, 5, 32'h400);
            streamTxn(1, 1'b0, 1, 32'h500);
        join
        repeat (10) @(negedge clk);
        checkOutput("prio_grant_count", gLog1.size() - base, 6);
        if (gLog1.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) checkOutput($sformatf("prio_order%0d", i), gLog1[base+i], ord1[i]);
            for (int i = 1; i < 5; i++) checkOutput($sformatf("prio_gap%0d", i), gCyc1[base+i] - gCyc1[base+i-1], 6);
        end

        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("dut%0d_mem_en_per_grant", d), memEnCnt[d], (d == 0) ? gLog0.size() : gLog1.size());
        end
        checkOutput("dut0_if_pending", ifQ0.size(), 0);
        checkOutput("dut0_d_pending", dQ0.size(), 0);
        checkOutput("dut1_if_pending", ifQ1.size(), 0);
        checkOutput("dut1_d_pending", dQ1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
